sram_bus_arbiter: RTL and testbench
===================================

# sram_bus_arbiter

Two-master, one-slave arbiter for the core's sram-like memory bus. It shares the single bus toward the AXI bridge between the instruction cache (inst port) and the data cache (data port). At most one transaction is outstanding at a time; grant is held from arbitration until the slave returns `data_ok`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  in  1  single clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `inst_req`, `inst_wr`  in  1  inst master request and write flag
- `inst_size`  in  2  inst master access size
- `inst_addr`  in  ADDR_W  inst master address
- `inst_wdata`  in  DATA_W  inst master write data
- `inst_rdata`  out  DATA_W  inst master read data
- `inst_addr_ok`, `inst_data_ok`  out  1  inst master handshakes
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_rdata`, `data_addr_ok`, `data_data_ok`: same widths and directions, data master
- `bus_req`, `bus_wr`  out  1  slave request and write flag
- `bus_size`  out  2  slave size
- `bus_addr`  out  ADDR_W  slave address
- `bus_wdata`  out  DATA_W  slave write data
- `bus_rdata`  in  DATA_W  slave read data
- `bus_addr_ok`, `bus_data_ok`  in  1  slave handshakes

## Operation
- States: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA; 3-bit registered state.
- IDLE: no bus activity. If `data_req` -> D_ADDR; else if `inst_req` -> I_ADDR; else stay. Both requesting: data wins (fixed priority; see Configuration).
- X_ADDR: `bus_req` = granted master's `req`; `bus_wr/size/addr/wdata` = granted master's fields. `X_addr_ok` = `bus_addr_ok & bus_req`, granted master only. On `bus_addr_ok`: `bus_data_ok` same cycle -> IDLE; otherwise -> X_DATA.
- X_DATA: `bus_req` = 0. `X_data_ok` = `bus_data_ok`, granted master only. On `bus_data_ok` -> IDLE.
- `inst_rdata` and `data_rdata` are both driven from `bus_rdata` unconditionally; valid only when the matching `data_ok` is 1.
- Non-granted master: `addr_ok` = `data_ok` = 0. Its request stays pending and is arbitrated on the next IDLE cycle.
- In IDLE and X_DATA, `bus_wr/size/addr/wdata` drive 0.
- Masters obey sram-like rules and hold `req` and fields stable until `addr_ok`. If the granted master drops `req` in X_ADDR, `bus_req` falls and the arbiter stays in X_ADDR. It never aborts or re-arbitrates.
- `bus_data_ok` received in IDLE or X_ADDR without a prior accepted address is ignored, and no master `data_ok` is raised.

## Timing
- Reset (`resetn`=0, async): state = IDLE. All outputs 0 except `*_rdata`, which follow `bus_rdata`. Reset mid-transaction drops the transaction. The slave and caches are reset together.
- Arbitration latency: `req` seen in IDLE at cycle N -> `bus_req` = 1 at cycle N+1.
- Minimum transaction: 3 cycles, from IDLE to back in IDLE (addr_ok and data_ok in the same cycle). Back-to-back grants take at least one IDLE cycle between transactions.
- `addr_ok` and `data_ok` toward the masters are combinational from the bus, with zero added latency.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: a 1-bit `last_data` register is set on every grant (1 = data granted, 0 = inst granted) and resets to 0. When both masters request in IDLE, the master not served last wins. With a single requester, that requester wins.
- Undefined: fixed priority, data over inst. The `last_data` register is absent.

## Test plan
- Single inst read: `inst_req`=1, addr 0xBFC00000. Slave gives `addr_ok` in cycle 2 and `data_ok` with rdata 0x3C08BFC0 in cycle 4. Required: `inst_addr_ok` in cycle 2, `inst_data_ok` with rdata 0x3C08BFC0 in cycle 4, and `data_*_ok` never asserted.
- Simultaneous requests: inst addr 0x100 and data write of 0xDEADBEEF to 0x200. Fixed priority: bus sees 0x200/wr=1 first, then 0x100 after one IDLE cycle. Round robin from reset: same order; a second simultaneous pair then grants inst first.
- Same-cycle handshake: `bus_addr_ok` and `bus_data_ok` both 1 in D_ADDR. Required: `data_addr_ok` and `data_data_ok` in that cycle, and state returns to IDLE next cycle.
- Stray `bus_data_ok` in IDLE: no master `data_ok`, and state stays IDLE.
- `resetn` pulsed low while in I_DATA: all handshake outputs go to 0 immediately. After release, a pending `data_req` is granted in the second cycle.
- Starvation check with round robin: both masters request continuously for 20 transactions. Grants must alternate strictly D, I, D, I, and so on.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like bus; one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority, data over inst.
module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } state_t;

    state_t state;
    logic   grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data;

    // Contention goes to whichever master was not granted last.
    always_comb begin
        grant_data = data_req & (~inst_req | ~last_data);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_data <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_data) begin
                last_data <= 1'b1;
            end else if (inst_req) begin
                last_data <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        grant_data = data_req;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state <= D_ADDR;
                    end else if (inst_req) begin
                        state <= I_ADDR;
                    end
                end
                I_ADDR: begin
                    if (bus_addr_ok && inst_req) begin
                        state <= bus_data_ok ? IDLE : I_DATA;
                    end
                end
                I_DATA: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                D_ADDR: begin
                    if (bus_addr_ok && data_req) begin
                        state <= bus_data_ok ? IDLE : D_DATA;
                    end
                end
                D_DATA: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshakes are pure decodes of state and bus inputs so the masters see zero added latency.
    always_comb begin
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = '0;
        bus_addr     = '0;
        bus_wdata    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            I_ADDR: begin
                bus_req      = inst_req;
                bus_wr       = inst_wr;
                bus_size     = inst_size;
                bus_addr     = inst_addr;
                bus_wdata    = inst_wdata;
                inst_addr_ok = bus_addr_ok & inst_req;
                inst_data_ok = bus_addr_ok & inst_req & bus_data_ok;
            end
            I_DATA: begin
                inst_data_ok = bus_data_ok;
            end
            D_ADDR: begin
                bus_req      = data_req;
                bus_wr       = data_wr;
                bus_size     = data_size;
                bus_addr     = data_addr;
                bus_wdata    = data_wdata;
                data_addr_ok = bus_addr_ok & data_req;
                data_data_ok = bus_addr_ok & data_req & bus_data_ok;
            end
            D_DATA: begin
                data_data_ok = bus_data_ok;
            end
            default: begin
            end
        endcase
    end

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: per-cycle vector table plus hand-written reset and fairness sequences.
// Expectations for the fairness sequence follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_sram_bus_arbiter;

    localparam logic [1:0]  ISZ = 2'b10;
    localparam logic [1:0]  DSZ = 2'b01;
    localparam logic [31:0] IWD = 32'h0000_1234;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_addr_ok, bus_data_ok;

    int n_checks = 0;
    int n_fail   = 0;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq, iwr;
        logic [31:0] iaddr;
        logic        dreq, dwr;
        logic [31:0] daddr, dwdata;
        logic        baok, bdok;
        logic [31:0] rdata;
        logic        breq, bwr;
        logic [1:0]  bsz;
        logic [31:0] baddr, bwdata;
        logic        iaok, idok, daok, ddok;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ireq, input logic iwr, input logic [31:0] iaddr,
                       input logic dreq, input logic dwr, input logic [31:0] daddr,
                       input logic [31:0] dwdata, input logic baok, input logic bdok,
                       input logic [31:0] rdata, input logic breq, input logic bwr,
                       input logic [1:0] bsz, input logic [31:0] baddr, input logic [31:0] bwdata,
                       input logic iaok, input logic idok, input logic daok, input logic ddok);
        vec_t v;
        v.ireq = ireq; v.iwr = iwr; v.iaddr = iaddr;
        v.dreq = dreq; v.dwr = dwr; v.daddr = daddr; v.dwdata = dwdata;
        v.baok = baok; v.bdok = bdok; v.rdata = rdata;
        v.breq = breq; v.bwr = bwr; v.bsz = bsz; v.baddr = baddr; v.bwdata = bwdata;
        v.iaok = iaok; v.idok = idok; v.daok = daok; v.ddok = ddok;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {56'h0, bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
                inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    endfunction

    function automatic logic [127:0] hs();
        return {123'h0, bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    endfunction

    initial begin
        int   n;
        logic exp_d;

        // single inst read
        add(1,0,32'hBFC00000, 0,0,0,0, 0,0,32'h0,         0,0,0,0,0,                    0,0,0,0);
        add(1,0,32'hBFC00000, 0,0,0,0, 1,0,32'h0,         1,0,ISZ,32'hBFC00000,IWD,     1,0,0,0);
        add(0,0,32'hBFC00000, 0,0,0,0, 0,0,32'h0,         0,0,0,0,0,                    0,0,0,0);
        add(0,0,32'hBFC00000, 0,0,0,0, 0,1,32'h3C08BFC0,  0,0,0,0,0,                    0,1,0,0);
        add(0,0,0,            0,0,0,0, 0,0,32'h1,         0,0,0,0,0,                    0,0,0,0);
        // simultaneous inst read / data write: data first, inst after one idle cycle
        add(1,0,32'h100, 1,1,32'h200,32'hDEADBEEF, 0,0,32'h0,  0,0,0,0,0,                 0,0,0,0);
        add(1,0,32'h100, 1,1,32'h200,32'hDEADBEEF, 1,0,32'h0,  1,1,DSZ,32'h200,32'hDEADBEEF, 0,0,1,0);
        add(1,0,32'h100, 0,0,0,0,                  0,1,32'h77, 0,0,0,0,0,                 0,0,0,1);
        add(1,0,32'h100, 0,0,0,0,                  0,0,32'h0,  0,0,0,0,0,                 0,0,0,0);
        add(1,0,32'h100, 0,0,0,0, 1,1,32'hCAFE0001,            1,0,ISZ,32'h100,IWD,       1,1,0,0);
        // same-cycle addr_ok/data_ok in D_ADDR, then stray data_ok in IDLE
        add(0,0,0, 1,0,32'h400,0, 0,0,32'h0,        0,0,0,0,0,              0,0,0,0);
        add(0,0,0, 1,0,32'h400,0, 1,1,32'h55AA55AA, 1,0,DSZ,32'h400,32'h0,  0,0,1,1);
        add(0,0,0, 0,0,0,0,       0,1,32'h9,        0,0,0,0,0,              0,0,0,0);
        // stray data_ok in I_ADDR, dropped req holds I_ADDR
        add(1,0,32'h500, 0,0,0,0, 0,0,32'h0,    0,0,0,0,0,              0,0,0,0);
        add(1,0,32'h500, 0,0,0,0, 0,1,32'h0,    1,0,ISZ,32'h500,IWD,    0,0,0,0);
        add(0,0,32'h500, 0,0,0,0, 1,0,32'h0,    0,0,ISZ,32'h500,IWD,    0,0,0,0);
        add(1,0,32'h500, 0,0,0,0, 1,0,32'h0,    1,0,ISZ,32'h500,IWD,    1,0,0,0);
        add(0,0,0,       0,0,0,0, 0,1,32'hABCD, 0,0,0,0,0,              0,1,0,0);
        add(0,0,0,       0,0,0,0, 0,0,32'h0,    0,0,0,0,0,              0,0,0,0);

        resetn = 1'b0;
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = ISZ; inst_addr = 32'h1; inst_wdata = IWD;
        data_req = 1'b1; data_wr = 1'b1; data_size = DSZ; data_addr = 32'h2; data_wdata = 32'h3;
        bus_rdata = 32'hA5A50F0F; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #3;
        check("reset_outputs", outs(), 128'h0);
        check("reset_rdata", {inst_rdata, data_rdata}, {32'hA5A50F0F, 32'hA5A50F0F});
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            inst_req = vecs[i].ireq; inst_wr = vecs[i].iwr; inst_addr = vecs[i].iaddr;
            data_req = vecs[i].dreq; data_wr = vecs[i].dwr; data_addr = vecs[i].daddr;
            data_wdata = vecs[i].dwdata;
            bus_addr_ok = vecs[i].baok; bus_data_ok = vecs[i].bdok; bus_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d_out", i), outs(),
                  {56'h0, vecs[i].breq, vecs[i].bwr, vecs[i].bsz, vecs[i].baddr, vecs[i].bwdata,
                   vecs[i].iaok, vecs[i].idok, vecs[i].daok, vecs[i].ddok});
            check($sformatf("vec%0d_rdata", i), {inst_rdata, data_rdata}, {vecs[i].rdata, vecs[i].rdata});
            @(posedge clk); #1;
        end

        // reset asserted in I_DATA with a data request pending
        inst_req = 1'b1; inst_addr = 32'h600; data_req = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        @(posedge clk); #1;
        bus_addr_ok = 1'b1;
        @(posedge clk); #1;
        inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h700;
        #1;
        check("idata_before_reset", hs(), 128'h4);
        resetn = 1'b0;
        #1;
        check("handshakes_in_reset", hs(), 128'h0);
        @(posedge clk); #1;
        resetn = 1'b1; bus_data_ok = 1'b0;
        @(negedge clk);
        check("post_reset_cycle1_idle", hs(), 128'h0);
        @(posedge clk); #1;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #1;
        check("post_reset_cycle2_grant", {bus_req, bus_addr, data_addr_ok, data_data_ok},
              {1'b1, 32'h700, 1'b1, 1'b1});
        @(posedge clk); #1;
        data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

        // fairness: both masters request continuously for 20 transactions
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h1000;
        data_req = 1'b1; data_addr = 32'h2000;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 20; c++) begin
            @(negedge clk);
            if (bus_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_d = (n % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                check($sformatf("grant%0d", n), {127'h0, bus_addr == 32'h2000}, {127'h0, exp_d});
                n++;
            end
        end
        if (n < 20) check("grant_count", n, 20);
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
